// File: rtl/chgroup_classifier.sv
// chgroup_classifier
//
// Purpose:
//   Sits downstream of the 64-input max tree. Each cycle it may take one
//   per-channel maximum together with that sample's pass threshold and
//   channel index. It assigns the channel to a power-of-two group relative
//   to the threshold, streams the group index out, and keeps a per-group
//   population histogram over a pass of NUM_CH channels.
//
//   Group g is the smallest k in [0, NUM_GROUPS-1] with
//   max_val > (Tmax_in >> (k+1)). If no k qualifies, g = NUM_GROUPS-1.
//   A sample above the threshold saturates into group 0 and raises sat_flag.
//
// Ports:
//   clk, rstn        single rising-edge clock, asynchronous active-low reset
//   start            begin a pass from IDLE, or abort and restart a running pass
//   valid_in         max_val / Tmax_in / Chidx_in valid this cycle (no backpressure)
//   max_val          channel maximum, unsigned
//   Tmax_in          pass threshold, unsigned
//   Chidx_in         channel index, passed through unchecked
//   cnt_rd_sel       histogram read select
//   cnt_rd_data      population of group cnt_rd_sel (combinational read)
//   gidx_valid       classification result valid
//   gidx_out         group index of the result
//   gidx_ch          channel index of the result
//   sat_flag         result was clamped to group 0 because max_val > Tmax_in
//   busy             FSM is not IDLE
//   done             one-cycle pulse: pass complete, histogram final
//   drop             one-cycle pulse: a valid_in arrived while not accepting

module chgroup_classifier #(
    parameter int DATA_W     = 16,
    parameter int NUM_GROUPS = 8,
    parameter int GIDX_W     = 3,
    parameter int NUM_CH     = 64,
    parameter int CNT_W      = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] max_val,
    input  logic [DATA_W-1:0] Tmax_in,
    input  logic [DATA_W-1:0] Chidx_in,
    input  logic [GIDX_W-1:0] cnt_rd_sel,
    output logic [CNT_W-1:0]  cnt_rd_data,
    output logic              gidx_valid,
    output logic [GIDX_W-1:0] gidx_out,
    output logic [DATA_W-1:0] gidx_ch,
    output logic              sat_flag,
    output logic              busy,
    output logic              done,
    output logic              drop
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] acc_next;

    // Control decoded from the current state and inputs
    logic accept;
    logic clear;
    logic flush;
    logic done_set;

    // Stage 1: registered inputs
    logic              s1_valid;
    logic [DATA_W-1:0] s1_max;
    logic [DATA_W-1:0] s1_tmax;
    logic [DATA_W-1:0] s1_ch;

    // Classification of the stage-1 sample
    logic [GIDX_W-1:0] class_g;
    logic              class_sat;

    // Per-group population histogram
    logic [CNT_W-1:0] count [NUM_GROUPS];

    // State and accept counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            acc_cnt <= '0;
        end else begin
            state   <= state_next;
            acc_cnt <= acc_next;
        end
    end

    // Next-state and control decode. A start outside IDLE is an abort: it
    // clears the histogram, flushes the pipeline and, unlike a start from
    // IDLE, accepts a coincident valid_in as channel 0 of the new pass.
    // DRAIN waits for stage 1 to empty; the stage-2 update of the last
    // sample lands on the same edge, so done is raised one edge later
    // together with the return to IDLE.
    always_comb begin
        state_next = state;
        acc_next   = acc_cnt;
        accept     = 1'b0;
        clear      = 1'b0;
        flush      = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    acc_next   = '0;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (start) begin
                    clear      = 1'b1;
                    flush      = 1'b1;
                    accept     = valid_in;
                    acc_next   = valid_in ? CNT_W'(1) : '0;
                    state_next = (valid_in && NUM_CH == 1) ? DRAIN : COLLECT;
                end else if (valid_in) begin
                    accept   = 1'b1;
                    acc_next = acc_cnt + CNT_W'(1);
                    if (acc_cnt == CNT_W'(NUM_CH - 1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (start) begin
                    clear      = 1'b1;
                    flush      = 1'b1;
                    accept     = valid_in;
                    acc_next   = valid_in ? CNT_W'(1) : '0;
                    state_next = (valid_in && NUM_CH == 1) ? DRAIN : COLLECT;
                end else if (!s1_valid) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stage 1 captures accepted samples. Only the valid bit matters on an
    // abort: the coincident sample, if any, is the first of the new pass.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_max   <= '0;
            s1_tmax  <= '0;
            s1_ch    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_max  <= max_val;
                s1_tmax <= Tmax_in;
                s1_ch   <= Chidx_in;
            end
        end
    end

    // Group search: scan from the coarsest group down so that the smallest
    // qualifying k wins. Shifts past the data width yield zero, so any
    // non-zero maximum qualifies at the deepest groups when Tmax is small.
    always_comb begin
        class_g = GIDX_W'(NUM_GROUPS - 1);
        for (int k = NUM_GROUPS - 1; k >= 0; k--) begin
            if (s1_max > (s1_tmax >> (k + 1))) begin
                class_g = GIDX_W'(k);
            end
        end
        class_sat = (s1_max > s1_tmax);
    end

    // Stage 2 issues the result. A flush drops whatever was in stage 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gidx_valid <= 1'b0;
            gidx_out   <= '0;
            gidx_ch    <= '0;
            sat_flag   <= 1'b0;
        end else begin
            gidx_valid <= s1_valid && !flush;
            if (s1_valid && !flush) begin
                gidx_out <= class_g;
                gidx_ch  <= s1_ch;
                sat_flag <= class_sat;
            end
        end
    end

    // Histogram update on the same edge a result issues. Clearing takes
    // priority, which also discards the count of a flushed sample. At most
    // NUM_CH results occur per pass, so the counters cannot wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_GROUPS; i++) begin
                count[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_GROUPS; i++) begin
                count[i] <= '0;
            end
        end else if (s1_valid) begin
            count[class_g] <= count[class_g] + CNT_W'(1);
        end
    end

    // Status pulses: done marks the final histogram, drop a rejected sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done <= 1'b0;
            drop <= 1'b0;
        end else begin
            done <= done_set;
            drop <= valid_in && !accept;
        end
    end

    assign busy        = (state != IDLE);
    assign cnt_rd_data = count[cnt_rd_sel];

endmodule
